// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared constants for the hex counter display
package hex_display_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs, bit 6 = g ... bit 0 = a: 0-9, A, b, C, d, E, F
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam int KEY_RUN  = 0;
  localparam int KEY_LOAD = 1;
  localparam int KEY_DIR  = 2;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronise and debounce one active-low pushbutton
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLOCK_50,
  input  logic Reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          state;
  logic [CW-1:0] cnt;

  // state only follows sync2 after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == state) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        state <= sync2;
        press <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_counter_display.sv
// rtl/hex_counter_display.sv - N-digit hex/BCD up/down counter on active-low 7-seg displays
import hex_display_pkg::*;

module hex_counter_display #(
  parameter int NUM_DIGITS      = 6,
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLANK_LZ        = 1
) (
  input  logic                    CLOCK_50,
  input  logic                    Reset,
  input  logic [2:0]              KEY,
  input  logic [3:0]              SW,
  input  logic                    mode_dec,
  output logic [7*NUM_DIGITS-1:0] hex_seg,
  output logic                    running,
  output logic                    dir_down,
  output logic                    wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [2:0]                    press;
  logic [PW-1:0]                 prescaler;
  logic                          tick;
  logic                          mode_q;
  logic                          mode_clear;
  digit_t [NUM_DIGITS-1:0]       digits;
  digit_t [NUM_DIGITS-1:0]       digits_step;
  digit_t [NUM_DIGITS-1:0]       digits_next;
  digit_t                        max_digit;
  digit_t                        load_nib;
  logic                          step_carry;
  logic                          wrap_next;
  logic                          nz_above;
  logic [7*NUM_DIGITS-1:0]       seg_next;

  genvar k;
  generate
    for (k = 0; k < 3; k++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .CLOCK_50(CLOCK_50),
        .Reset   (Reset),
        .key_n   (KEY[k]),
        .press   (press[k])
      );
    end
  endgenerate

  assign tick       = (prescaler == PW'(TICK_DIV - 1)) && running;
  assign mode_clear = mode_dec && !mode_q;
  assign max_digit  = mode_dec ? 4'd9 : 4'd15;
  assign load_nib   = (mode_dec && (SW > 4'd9)) ? 4'd9 : SW;

  // Ripple one step through the digits; a carry out of the top digit is a wrap
  always_comb begin
    digits_step = digits;
    step_carry  = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (step_carry) begin
        if (!dir_down) begin
          if (digits[i] >= max_digit) begin
            digits_step[i] = 4'd0;
          end else begin
            digits_step[i] = digits[i] + 4'd1;
            step_carry     = 1'b0;
          end
        end else begin
          if (digits[i] == 4'd0) begin
            digits_step[i] = max_digit;
          end else begin
            digits_step[i] = digits[i] - 4'd1;
            step_carry     = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    digits_next = digits;
    wrap_next   = 1'b0;
    if (mode_clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (digits[i] > 4'd9) digits_next[i] = 4'd0;
      end
    end else if (press[KEY_LOAD]) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        digits_next[i] = digits[i-1];
      end
      digits_next[0] = load_nib;
    end else if (tick) begin
      digits_next = digits_step;
      wrap_next   = step_carry;
    end
  end

  // Scan from the top digit so blanking knows whether anything above is non-zero
  always_comb begin
    seg_next = '0;
    nz_above = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_above = nz_above | (digits[i] != 4'd0);
      if ((BLANK_LZ != 0) && (i > 0) && !nz_above) begin
        seg_next[7*i +: 7] = SEG_BLANK;
      end else begin
        seg_next[7*i +: 7] = SEG_GLYPH[digits[i]];
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      prescaler <= '0;
      mode_q    <= 1'b0;
      digits    <= '0;
      running   <= 1'b0;
      dir_down  <= 1'b0;
      wrap      <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_seg[7*i +: 7] <= ((i == 0) || (BLANK_LZ == 0)) ? SEG_GLYPH[0] : SEG_BLANK;
      end
    end else begin
      prescaler <= (prescaler == PW'(TICK_DIV - 1)) ? '0 : prescaler + 1'b1;
      mode_q    <= mode_dec;
      digits    <= digits_next;
      wrap      <= wrap_next;
      running   <= running ^ press[KEY_RUN];
      dir_down  <= dir_down ^ press[KEY_DIR];
      hex_seg   <= seg_next;
    end
  end

endmodule

// File: tb/tb_hex_counter_display.sv
// tb/tb_hex_counter_display.sv - directed self-checking bench for hex_counter_display
module tb_hex_counter_display;

  logic        CLOCK_50 = 1'b0;
  logic        Reset    = 1'b1;
  logic [2:0]  KEY      = 3'b111;
  logic [3:0]  SW       = 4'h0;
  logic        mode_dec = 1'b0;
  logic [20:0] hex_seg;
  logic        running;
  logic        dir_down;
  logic        wrap;

  int total    = 0;
  int bad      = 0;
  int wrap_cnt = 0;
  int cyc      = 0;

  hex_counter_display #(
    .NUM_DIGITS     (3),
    .TICK_DIV       (4),
    .DEBOUNCE_CYCLES(3),
    .BLANK_LZ       (1)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Reset   (Reset),
    .KEY     (KEY),
    .SW      (SW),
    .mode_dec(mode_dec),
    .hex_seg (hex_seg),
    .running (running),
    .dir_down(dir_down),
    .wrap    (wrap)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Edges since reset; equals the prescaler phase modulo TICK_DIV
  always @(posedge CLOCK_50) cyc <= Reset ? 0 : cyc + 1;

  always @(negedge CLOCK_50) if (wrap === 1'b1) wrap_cnt++;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  function automatic logic [20:0] exp_seg(input logic [11:0] v);
    logic [6:0] s2, s1;
    s2 = (v[11:8] == 4'h0) ? 7'h7F : glyph(v[11:8]);
    s1 = (v[11:4] == 8'h00) ? 7'h7F : glyph(v[7:4]);
    exp_seg = {s2, s1, glyph(v[3:0])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_disp(input string tag, input logic [11:0] v, input int budget);
    int n = 0;
    while (hex_seg !== exp_seg(v) && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk(tag, 32'(hex_seg), 32'(exp_seg(v)));
  endtask

  task automatic press(input int k);
    KEY[k] = 1'b0;
    repeat (6) @(negedge CLOCK_50);
    KEY[k] = 1'b1;
    repeat (6) @(negedge CLOCK_50);
  endtask

  task automatic load(input logic [3:0] nib);
    SW = nib;
    press(1);
  endtask

  initial begin
    int n;
    // 1: reset state and bounce rejection
    repeat (3) @(negedge CLOCK_50);
    chk("rst_seg", 32'(hex_seg), 32'({7'h7F, 7'h7F, 7'h40}));
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_dir", 32'(dir_down), 32'd0);
    Reset = 1'b0;
    KEY[0] = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    KEY[0] = 1'b1;
    repeat (8) @(negedge CLOCK_50);
    chk("bounce_running", 32'(running), 32'd0);

    // 2: count up, one step per TICK_DIV cycles
    KEY[0] = 1'b0;
    wait_disp("up_001", 12'h001, 40);
    KEY[0] = 1'b1;
    chk("run_on", 32'(running), 32'd1);
    repeat (3) @(negedge CLOCK_50);
    chk("hold_001", 32'(hex_seg), 32'(exp_seg(12'h001)));
    @(negedge CLOCK_50);
    chk("up_002", 32'(hex_seg), 32'(exp_seg(12'h002)));
    repeat (4) @(negedge CLOCK_50);
    chk("up_003", 32'(hex_seg), 32'(exp_seg(12'h003)));
    repeat (4) @(negedge CLOCK_50);
    chk("up_004", 32'(hex_seg), 32'({7'h7F, 7'h7F, 7'h19}));
    wait_disp("up_00F", 12'h00F, 60);
    chk("blank_d1_00F", 32'(hex_seg[13:7]), 32'h7F);
    repeat (4) @(negedge CLOCK_50);
    chk("up_010", 32'(hex_seg), 32'({7'h7F, 7'h79, 7'h40}));
    press(0);
    chk("pause", 32'(running), 32'd0);

    // 3: hex wrap up then down
    load(4'hF); load(4'hF); load(4'hF);
    chk("load_FFF", 32'(hex_seg), 32'({7'h0E, 7'h0E, 7'h0E}));
    wrap_cnt = 0;
    KEY[0] = 1'b0;
    wait_disp("wrap_up_000", 12'h000, 40);
    KEY[0] = 1'b1;
    chk("wrap_up_pulse", 32'(wrap_cnt), 32'd1);
    wrap_cnt = 0;
    press(2);
    chk("dir_down_on", 32'(dir_down), 32'd1);
    wait_disp("wrap_dn_FFF", 12'hFFF, 20);
    chk("wrap_dn_pulse", 32'(wrap_cnt), 32'd1);
    press(0);
    chk("pause2", 32'(running), 32'd0);

    // 4: decimal wrap and load clamp
    mode_dec = 1'b1;
    press(2);
    chk("dir_up_again", 32'(dir_down), 32'd0);
    load(4'h9); load(4'h9); load(4'h9);
    chk("load_999", 32'(hex_seg), 32'({7'h10, 7'h10, 7'h10}));
    wrap_cnt = 0;
    KEY[0] = 1'b0;
    wait_disp("dec_wrap_000", 12'h000, 40);
    KEY[0] = 1'b1;
    chk("dec_wrap_pulse", 32'(wrap_cnt), 32'd1);
    repeat (8) @(negedge CLOCK_50);
    press(0);
    chk("pause3", 32'(running), 32'd0);
    load(4'hC);
    chk("clamp_C_to_9", 32'(hex_seg[6:0]), 32'h10);

    // 5: mode-change clear drops a coincident tick
    mode_dec = 1'b0;
    load(4'h0); load(4'hA); load(4'h3);
    chk("load_0A3", 32'(hex_seg), 32'({7'h7F, 7'h08, 7'h30}));
    KEY[0] = 1'b0;
    n = 0;
    while (running !== 1'b1 && n < 30) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("run_for_clear", 32'(running), 32'd1);
    n = 0;
    while ((cyc % 4) != 3 && n < 10) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("pre_clear_0A3", 32'(hex_seg), 32'({7'h7F, 7'h08, 7'h30}));
    mode_dec = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    KEY[0] = 1'b1;
    chk("clear_003", 32'(hex_seg), 32'({7'h7F, 7'h7F, 7'h30}));
    chk("clear_no_wrap", 32'(wrap), 32'd0);

    // 6: reset during a tick and mid-debounce
    n = 0;
    while ((cyc % 4) != 1 && n < 10) begin
      @(negedge CLOCK_50);
      n++;
    end
    SW = 4'h5;
    KEY[1] = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    Reset = 1'b1;
    @(negedge CLOCK_50);
    chk("mid_rst_seg", 32'(hex_seg), 32'({7'h7F, 7'h7F, 7'h40}));
    chk("mid_rst_running", 32'(running), 32'd0);
    chk("mid_rst_dir", 32'(dir_down), 32'd0);
    chk("mid_rst_wrap", 32'(wrap), 32'd0);
    Reset = 1'b0;
    KEY[1] = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    chk("no_load_after_rst", 32'(hex_seg), 32'({7'h7F, 7'h7F, 7'h40}));
    chk("still_paused", 32'(running), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
